// File: rtl/reg_bank_pkg.sv
// Shared constants and helpers for the byte-enabled register bank.
// byte_merge works on a fixed maximum width; callers extend and truncate.
package reg_bank_pkg;

  localparam int BYTE_W      = 8;
  localparam int MERGE_MAX_W = 1024;
  localparam int MERGE_MAX_B = MERGE_MAX_W / BYTE_W;

  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Replace every byte of old_w whose enable is set with the matching byte of new_w.
  function automatic logic [MERGE_MAX_W-1:0] byte_merge(
    input logic [MERGE_MAX_W-1:0] old_w,
    input logic [MERGE_MAX_W-1:0] new_w,
    input logic [MERGE_MAX_B-1:0] be
  );
    logic [MERGE_MAX_W-1:0] res;
    res = old_w;
    for (int i = 0; i < MERGE_MAX_B; i++) begin
      if (be[i]) begin
        res[i*BYTE_W +: BYTE_W] = new_w[i*BYTE_W +: BYTE_W];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/reg_bank_word.sv
// One register of the bank: asynchronous active-low clear, byte-enabled load.
module reg_bank_word
  import reg_bank_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_i,
  input  logic [WIDTH/BYTE_W-1:0] be_i,
  input  logic [WIDTH-1:0]        data_i,
  output logic [WIDTH-1:0]        q_o
);

  logic [WIDTH-1:0] word_q;
  logic [WIDTH-1:0] word_d;

  always_comb begin
    word_d = word_q;
    if (load_i) begin
      word_d = WIDTH'(byte_merge(MERGE_MAX_W'(word_q), MERGE_MAX_W'(data_i),
                                 MERGE_MAX_B'(be_i)));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
    end else begin
      word_q <= word_d;
    end
  end

  assign q_o = word_q;

endmodule

// File: rtl/reg_bank.sv
// Multi-ported register bank: one byte-enabled write port, NUM_RD combinational
// read ports with write-through bypass, optional hard-wired zero register.
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter int  WIDTH    = 32,
  parameter int  DEPTH    = 32,
  parameter int  NUM_RD   = 2,
  parameter int  ZERO_REG = 1,
  localparam int ADDR_W   = addr_width(DEPTH),
  localparam int BE_W     = WIDTH / BYTE_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [BE_W-1:0]          wr_be,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*WIDTH-1:0]  rd_data,
  output logic                     wr_drop
);

  logic             wr_fire;
  logic             zero_hit;
  logic             wr_store;
  logic [WIDTH-1:0] wr_merged;
  logic [WIDTH-1:0] word_val [DEPTH];

  // Gating with rst_n discards a write on an edge that coincides with reset
  // and keeps the bypass path quiet while reset is held.
  assign wr_fire  = rst_n & wr_en & (|wr_be);
  assign zero_hit = (ZERO_REG != 0) && (wr_addr == '0);
  assign wr_store = wr_fire & ~zero_hit;

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    if ((ZERO_REG != 0) && (i == 0)) begin : g_zero
      assign word_val[i] = '0;
    end else begin : g_reg
      reg_bank_word #(
        .WIDTH (WIDTH)
      ) u_word (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (wr_store && (wr_addr == ADDR_W'(i))),
        .be_i   (wr_be),
        .data_i (wr_data),
        .q_o    (word_val[i])
      );
    end
  end

  assign wr_merged = WIDTH'(byte_merge(MERGE_MAX_W'(word_val[wr_addr]),
                                       MERGE_MAX_W'(wr_data),
                                       MERGE_MAX_B'(wr_be)));

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  word;

    assign addr = rd_addr[p*ADDR_W +: ADDR_W];

    // wr_store already excludes the zero register, so address 0 stays 0 here.
    always_comb begin
      word = word_val[addr];
      if (wr_store && (wr_addr == addr)) begin
        word = wr_merged;
      end
      if (!rst_n) begin
        word = '0;
      end
    end

    assign rd_data[p*WIDTH +: WIDTH] = word;
  end

  if (ZERO_REG != 0) begin : g_drop
    logic drop_q;
    logic drop_d;

    assign drop_d = wr_fire & zero_hit;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        drop_q <= 1'b0;
      end else begin
        drop_q <= drop_d;
      end
    end

    assign wr_drop = drop_q;
  end else begin : g_no_drop
    assign wr_drop = 1'b0;
  end

endmodule

// File: tb/tb_reg_bank.sv
// Bench for reg_bank: directed scenarios on the default configuration, a
// ZERO_REG=0 twin, and a randomized sweep on two extreme configurations.
module tb_reg_bank;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_mis;

  // u_a: WIDTH=32 DEPTH=32 NUM_RD=2 ZERO_REG=1
  logic        a_wr_en;
  logic [4:0]  a_wr_addr;
  logic [31:0] a_wr_data;
  logic [3:0]  a_wr_be;
  logic [9:0]  a_rd_addr;
  logic [63:0] a_rd_data;
  logic        a_wr_drop;

  // u_b: WIDTH=32 DEPTH=32 NUM_RD=2 ZERO_REG=0
  logic        b_wr_en;
  logic [4:0]  b_wr_addr;
  logic [31:0] b_wr_data;
  logic [3:0]  b_wr_be;
  logic [9:0]  b_rd_addr;
  logic [63:0] b_rd_data;
  logic        b_wr_drop;

  // u_c: WIDTH=8 DEPTH=2 NUM_RD=1 ZERO_REG=1
  logic        c_wr_en;
  logic [0:0]  c_wr_addr;
  logic [7:0]  c_wr_data;
  logic [0:0]  c_wr_be;
  logic [0:0]  c_rd_addr;
  logic [7:0]  c_rd_data;
  logic        c_wr_drop;

  // u_d: WIDTH=64 DEPTH=64 NUM_RD=4 ZERO_REG=0
  logic         d_wr_en;
  logic [5:0]   d_wr_addr;
  logic [63:0]  d_wr_data;
  logic [7:0]   d_wr_be;
  logic [23:0]  d_rd_addr;
  logic [255:0] d_rd_data;
  logic         d_wr_drop;

  reg_bank #(.WIDTH(32), .DEPTH(32), .NUM_RD(2), .ZERO_REG(1)) u_a (
    .clk(clk), .rst_n(rst_n), .wr_en(a_wr_en), .wr_addr(a_wr_addr),
    .wr_data(a_wr_data), .wr_be(a_wr_be), .rd_addr(a_rd_addr),
    .rd_data(a_rd_data), .wr_drop(a_wr_drop));

  reg_bank #(.WIDTH(32), .DEPTH(32), .NUM_RD(2), .ZERO_REG(0)) u_b (
    .clk(clk), .rst_n(rst_n), .wr_en(b_wr_en), .wr_addr(b_wr_addr),
    .wr_data(b_wr_data), .wr_be(b_wr_be), .rd_addr(b_rd_addr),
    .rd_data(b_rd_data), .wr_drop(b_wr_drop));

  reg_bank #(.WIDTH(8), .DEPTH(2), .NUM_RD(1), .ZERO_REG(1)) u_c (
    .clk(clk), .rst_n(rst_n), .wr_en(c_wr_en), .wr_addr(c_wr_addr),
    .wr_data(c_wr_data), .wr_be(c_wr_be), .rd_addr(c_rd_addr),
    .rd_data(c_rd_data), .wr_drop(c_wr_drop));

  reg_bank #(.WIDTH(64), .DEPTH(64), .NUM_RD(4), .ZERO_REG(0)) u_d (
    .clk(clk), .rst_n(rst_n), .wr_en(d_wr_en), .wr_addr(d_wr_addr),
    .wr_data(d_wr_data), .wr_be(d_wr_be), .rd_addr(d_rd_addr),
    .rd_data(d_rd_data), .wr_drop(d_wr_drop));

  // Clock and reset: posedges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis + 1);
    $fatal(1, "watchdog");
  end

  // Reference helpers
  function automatic logic [63:0] merge_bytes(input logic [63:0] old_w,
                                              input logic [63:0] new_w,
                                              input logic [7:0]  be);
    logic [63:0] r;
    r = old_w;
    for (int k = 0; k < 8; k++) begin
      if (be[k]) r[k*8 +: 8] = new_w[k*8 +: 8];
    end
    return r;
  endfunction

  function automatic logic [31:0] a_rd(input int p);
    return a_rd_data[p*32 +: 32];
  endfunction

  function automatic logic [31:0] b_rd(input int p);
    return b_rd_data[p*32 +: 32];
  endfunction

  // Driver tasks
  task automatic a_write(input logic [4:0] addr, input logic [31:0] data,
                         input logic [3:0] be);
    @(negedge clk);
    a_wr_en   = 1'b1;
    a_wr_addr = addr;
    a_wr_data = data;
    a_wr_be   = be;
    @(posedge clk);
    #1;
    a_wr_en = 1'b0;
    a_wr_be = 4'h0;
  endtask

  task automatic idle_all();
    a_wr_en = 1'b0; a_wr_addr = '0; a_wr_data = '0; a_wr_be = '0; a_rd_addr = '0;
    b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0; b_wr_be = '0; b_rd_addr = '0;
    c_wr_en = 1'b0; c_wr_addr = '0; c_wr_data = '0; c_wr_be = '0; c_rd_addr = '0;
    d_wr_en = 1'b0; d_wr_addr = '0; d_wr_data = '0; d_wr_be = '0; d_rd_addr = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    n_cmp++;
    if (a_rd_data !== 64'h0) begin
      n_mis++;
      $display("FAIL reset_por_read: got %h expected 0", a_rd_data);
    end
    n_cmp++;
    if (a_wr_drop !== 1'b0) begin
      n_mis++;
      $display("FAIL reset_por_drop: got %b expected 0", a_wr_drop);
    end
    #9 rst_n = 1'b1;

    a_write(5'd4, 32'h01020304, 4'hf);
    a_write(5'd31, 32'hffffffff, 4'hf);
    @(negedge clk);
    a_rd_addr = {5'd31, 5'd4};
    #1;
    n_cmp++;
    if (a_rd(0) !== 32'h01020304) begin
      n_mis++;
      $display("FAIL reset_preload4: got %h expected 01020304", a_rd(0));
    end
    n_cmp++;
    if (a_rd(1) !== 32'hffffffff) begin
      n_mis++;
      $display("FAIL reset_preload31: got %h expected ffffffff", a_rd(1));
    end

    // Reset pulse entirely inside the low clock phase, with a write pending.
    a_wr_en = 1'b1; a_wr_addr = 5'd6; a_wr_data = 32'h66666666; a_wr_be = 4'hf;
    a_rd_addr = {5'd6, 5'd4};
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (a_rd(0) !== 32'h0) begin
      n_mis++;
      $display("FAIL reset_async_clear: got %h expected 0", a_rd(0));
    end
    n_cmp++;
    if (a_rd(1) !== 32'h0) begin
      n_mis++;
      $display("FAIL reset_bypass_off: got %h expected 0", a_rd(1));
    end
    a_wr_en = 1'b0;
    a_wr_be = 4'h0;
    #1 rst_n = 1'b1;
    #1;
    for (int i = 0; i < 32; i++) begin
      a_rd_addr = {5'(31 - i), 5'(i)};
      #1;
      n_cmp++;
      if (a_rd_data !== 64'h0) begin
        n_mis++;
        $display("FAIL reset_sweep addr %0d: got %h expected 0", i, a_rd_data);
      end
    end
  endtask

  task automatic test_byte_enable();
    a_write(5'd5, 32'hAABBCCDD, 4'b1111);
    a_write(5'd5, 32'h11223344, 4'b0101);
    @(negedge clk);
    a_rd_addr = {5'd5, 5'd5};
    #1;
    n_cmp++;
    if (a_rd_data !== {32'hAA22CC44, 32'hAA22CC44}) begin
      n_mis++;
      $display("FAIL byte_enable: got %h expected aa22cc44 on both ports", a_rd_data);
    end
    a_write(5'd5, 32'hFFFFFFFF, 4'b0000);
    a_write(5'd0, 32'h12345678, 4'b0000);
    #1;
    n_cmp++;
    if (a_rd(0) !== 32'hAA22CC44) begin
      n_mis++;
      $display("FAIL be_zero_hold: got %h expected aa22cc44", a_rd(0));
    end
    n_cmp++;
    if (a_wr_drop !== 1'b0) begin
      n_mis++;
      $display("FAIL be_zero_nodrop: got %b expected 0", a_wr_drop);
    end
  endtask

  task automatic test_bypass();
    a_write(5'd7, 32'h0000FFFF, 4'hf);
    a_write(5'd3, 32'h33CC33CC, 4'hf);
    @(negedge clk);
    a_rd_addr = {5'd3, 5'd7};
    a_wr_en = 1'b1; a_wr_addr = 5'd7; a_wr_data = 32'h12345678; a_wr_be = 4'b1100;
    #1;
    n_cmp++;
    if (a_rd(0) !== 32'h1234FFFF) begin
      n_mis++;
      $display("FAIL bypass_same_cycle: got %h expected 1234ffff", a_rd(0));
    end
    n_cmp++;
    if (a_rd(1) !== 32'h33CC33CC) begin
      n_mis++;
      $display("FAIL bypass_other_port: got %h expected 33cc33cc", a_rd(1));
    end
    @(posedge clk);
    #1;
    a_wr_en = 1'b0;
    a_wr_be = 4'h0;
    #1;
    n_cmp++;
    if (a_rd(0) !== 32'h1234FFFF) begin
      n_mis++;
      $display("FAIL bypass_stored: got %h expected 1234ffff", a_rd(0));
    end
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    a_rd_addr = 10'h0;
    b_rd_addr = 10'h0;
    a_wr_en = 1'b1; a_wr_addr = 5'd0; a_wr_data = 32'hDEADBEEF; a_wr_be = 4'hf;
    b_wr_en = 1'b1; b_wr_addr = 5'd0; b_wr_data = 32'hDEADBEEF; b_wr_be = 4'hf;
    #1;
    n_cmp++;
    if (a_rd(0) !== 32'h0) begin
      n_mis++;
      $display("FAIL zero_bypass_z1: got %h expected 0", a_rd(0));
    end
    n_cmp++;
    if (b_rd(0) !== 32'hDEADBEEF) begin
      n_mis++;
      $display("FAIL zero_bypass_z0: got %h expected deadbeef", b_rd(0));
    end
    @(posedge clk);
    #1;
    a_wr_en = 1'b0; a_wr_be = 4'h0;
    b_wr_en = 1'b0; b_wr_be = 4'h0;
    #1;
    n_cmp++;
    if (a_rd(1) !== 32'h0) begin
      n_mis++;
      $display("FAIL zero_read_z1: got %h expected 0", a_rd(1));
    end
    n_cmp++;
    if (b_rd(1) !== 32'hDEADBEEF) begin
      n_mis++;
      $display("FAIL zero_read_z0: got %h expected deadbeef", b_rd(1));
    end
    n_cmp++;
    if (a_wr_drop !== 1'b1) begin
      n_mis++;
      $display("FAIL zero_drop_pulse: got %b expected 1", a_wr_drop);
    end
    n_cmp++;
    if (b_wr_drop !== 1'b0) begin
      n_mis++;
      $display("FAIL zero_drop_z0: got %b expected 0", b_wr_drop);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (a_wr_drop !== 1'b0) begin
      n_mis++;
      $display("FAIL zero_drop_one_cycle: got %b expected 0", a_wr_drop);
    end
    n_cmp++;
    if (b_wr_drop !== 1'b0) begin
      n_mis++;
      $display("FAIL zero_drop_z0_late: got %b expected 0", b_wr_drop);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_v;
    logic [31:0] nd;
    logic [3:0]  nb;
    exp_v = 32'h0;
    a_write(5'd12, 32'h0, 4'hf);
    a_rd_addr = {5'd12, 5'd0};
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      nd = $urandom;
      nb = 4'($urandom_range(1, 15));
      a_wr_en = 1'b1; a_wr_addr = 5'd12; a_wr_data = nd; a_wr_be = nb;
      #1;
      n_cmp++;
      if (a_rd(1) !== merge_bytes({32'h0, exp_v}, {32'h0, nd}, {4'h0, nb}) >> 0 &&
          a_rd(1) !== 32'(merge_bytes({32'h0, exp_v}, {32'h0, nd}, {4'h0, nb}))) begin
        n_mis++;
        $display("FAIL b2b_bypass step %0d: got %h", k, a_rd(1));
      end
      exp_v = 32'(merge_bytes({32'h0, exp_v}, {32'h0, nd}, {4'h0, nb}));
    end
    @(posedge clk);
    #1;
    a_wr_en = 1'b0;
    a_wr_be = 4'h0;
    #1;
    n_cmp++;
    if (a_rd(1) !== exp_v) begin
      n_mis++;
      $display("FAIL b2b_final: got %h expected %h", a_rd(1), exp_v);
    end
  endtask

  task automatic test_reset_mid_write();
    @(negedge clk);
    a_rd_addr = {5'd0, 5'd9};
    a_wr_en = 1'b1; a_wr_addr = 5'd9; a_wr_data = 32'hCAFEF00D; a_wr_be = 4'hf;
    #4 rst_n = 1'b0;
    @(posedge clk);
    #1;
    a_wr_en = 1'b0;
    a_wr_be = 4'h0;
    #1 rst_n = 1'b1;
    #1;
    n_cmp++;
    if (a_rd(0) !== 32'h0) begin
      n_mis++;
      $display("FAIL reset_mid_write: got %h expected 0", a_rd(0));
    end
    a_write(5'd9, 32'h0BADF00D, 4'hf);
    #1;
    n_cmp++;
    if (a_rd(0) !== 32'h0BADF00D) begin
      n_mis++;
      $display("FAIL first_write_after_reset: got %h expected 0badf00d", a_rd(0));
    end
  endtask

  // Randomized sweep on the 8x2x1 (zero reg) and 64x64x4 (no zero reg) banks.
  task automatic test_random();
    logic [7:0]  mc [2];
    logic [63:0] md [64];
    logic [0:0]  exp_q [$];
    logic [7:0]  e8;
    logic [63:0] e64;
    logic [5:0]  ad;
    logic [0:0]  ed;
    for (int i = 0; i < 2; i++) mc[i] = 8'h0;
    for (int i = 0; i < 64; i++) md[i] = 64'h0;
    exp_q.push_back(1'b0);
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge clk);
      c_wr_en   = 1'($urandom_range(0, 1));
      c_wr_addr = 1'($urandom_range(0, 1));
      c_wr_data = 8'($urandom);
      c_wr_be   = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
      c_rd_addr = ($urandom_range(0, 1) == 0) ? c_wr_addr : 1'($urandom_range(0, 1));
      d_wr_en   = 1'($urandom_range(0, 1));
      d_wr_addr = 6'($urandom_range(0, 63));
      d_wr_data = {$urandom, $urandom};
      d_wr_be   = ($urandom_range(0, 7) == 0) ? 8'h0 : 8'($urandom);
      for (int p = 0; p < 4; p++) begin
        d_rd_addr[p*6 +: 6] = ($urandom_range(0, 2) == 0) ? d_wr_addr
                                                          : 6'($urandom_range(0, 63));
      end
      #1;
      ed = exp_q.pop_front();
      n_cmp++;
      if (c_wr_drop !== ed) begin
        n_mis++;
        $display("FAIL rand_c_drop cyc %0d: got %b expected %b", cyc, c_wr_drop, ed);
      end
      if (c_rd_addr == 1'b0) begin
        e8 = 8'h0;
      end else begin
        e8 = mc[c_rd_addr];
        if (c_wr_en && c_wr_be[0] && (c_wr_addr == c_rd_addr)) e8 = c_wr_data;
      end
      n_cmp++;
      if (c_rd_data !== e8) begin
        n_mis++;
        $display("FAIL rand_c_read cyc %0d: got %h expected %h", cyc, c_rd_data, e8);
      end
      for (int p = 0; p < 4; p++) begin
        ad  = d_rd_addr[p*6 +: 6];
        e64 = md[ad];
        if (d_wr_en && (d_wr_be != 8'h0) && (d_wr_addr == ad)) begin
          e64 = merge_bytes(e64, d_wr_data, d_wr_be);
        end
        n_cmp++;
        if (d_rd_data[p*64 +: 64] !== e64) begin
          n_mis++;
          $display("FAIL rand_d_read cyc %0d port %0d: got %h expected %h",
                   cyc, p, d_rd_data[p*64 +: 64], e64);
        end
      end
      n_cmp++;
      if (d_wr_drop !== 1'b0) begin
        n_mis++;
        $display("FAIL rand_d_drop cyc %0d: got %b expected 0", cyc, d_wr_drop);
      end
      // Commit the writes the coming edge performs.
      exp_q.push_back((c_wr_en && c_wr_be[0] && (c_wr_addr == 1'b0)) ? 1'b1 : 1'b0);
      if (c_wr_en && c_wr_be[0] && (c_wr_addr != 1'b0)) mc[c_wr_addr] = c_wr_data;
      if (d_wr_en && (d_wr_be != 8'h0)) md[d_wr_addr] = merge_bytes(md[d_wr_addr], d_wr_data, d_wr_be);
    end
    @(negedge clk);
    c_wr_en = 1'b0;
    d_wr_en = 1'b0;
    #1;
    ed = exp_q.pop_front();
    n_cmp++;
    if (c_wr_drop !== ed) begin
      n_mis++;
      $display("FAIL rand_c_drop_last: got %b expected %b", c_wr_drop, ed);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    idle_all();
    test_reset();
    test_byte_enable();
    test_bypass();
    test_zero_reg();
    test_back_to_back();
    test_reset_mid_write();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
